// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule slice: round count, word/key
// types, controller state encoding, Rcon lookup and GF(2^8) helpers used by
// the S-box.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_key_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2,
      REWIND = 2'd3
   } aes_state_e;

   // Round constant for round index 1..10; other indices return zero.
   function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // Cyclic left rotation of a word by one byte.
   function automatic aes_word_t aes_rot_word(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   // Multiply by x modulo the AES polynomial.
   function automatic logic [7:0] aes_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply, shift-and-add.
   function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         else      acc = acc;
         aa = aes_xtime(aa);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0).
   function automatic logic [7:0] aes_gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = aes_gf_mul(x, x);
      x3   = aes_gf_mul(x2, x);
      x6   = aes_gf_mul(x3, x3);
      x12  = aes_gf_mul(x6, x6);
      x15  = aes_gf_mul(x12, x3);
      x30  = aes_gf_mul(x15, x15);
      x60  = aes_gf_mul(x30, x30);
      x120 = aes_gf_mul(x60, x60);
      x240 = aes_gf_mul(x120, x120);
      x252 = aes_gf_mul(x240, x12);
      return aes_gf_mul(x252, x2);
   endfunction

   // Left rotate a byte by n positions (n < 8).
   function automatic logic [7:0] aes_rotl8(input logic [7:0] b, input logic [2:0] n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // Forward S-box affine transform.
   function automatic logic [7:0] aes_affine(input logic [7:0] b);
      return b ^ aes_rotl8(b, 3'd1) ^ aes_rotl8(b, 3'd2) ^ aes_rotl8(b, 3'd3)
               ^ aes_rotl8(b, 3'd4) ^ 8'h63;
   endfunction

   // Inverse of the S-box affine transform.
   function automatic logic [7:0] aes_inv_affine(input logic [7:0] b);
      return aes_rotl8(b, 3'd1) ^ aes_rotl8(b, 3'd3) ^ aes_rotl8(b, 3'd6) ^ 8'h05;
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord datapath: four byte S-boxes. The S-box supports both directions so
// the same cell serves the cipher and inverse cipher; the key schedule always
// needs the forward direction, so the select is tied low here.
module aes_sbox
   import aes_pkg::*;
(
   input  logic       dec,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   // Forward: inverse then affine. Inverse: inverse-affine then inverse.
   always_comb begin
      dout = 8'h00;
      if (dec) dout = aes_gf_inv(aes_inv_affine(din));
      else     dout = aes_affine(aes_gf_inv(din));
   end

endmodule

module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .dec  (1'b0),
         .din  (word_in[8*b +: 8]),
         .dout (word_out[8*b +: 8])
      );
   end

endmodule

// File: rtl/aes_key_sched_rev.sv
// Iterative AES-128 key schedule for the inverse cipher. A load expands the
// cipher key forward to the round-10 key, then each request steps one round
// key backward. One SubWord instance is shared by the forward and reverse
// step. Optional macro AES_KS_REWIND_EN keeps a copy of the round-10 key so a
// rewind completes in one cycle; without it a rewind re-expands forward.
module aes_key_sched_rev
   import aes_pkg::*;
#(
   parameter int NR = AES_NR,
   parameter int RW = 4
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [127:0]  key_i,
   input  logic          key_load_i,
   input  logic          rk_next_i,
   input  logic          rk_rewind_i,
   output logic [127:0]  rk_o,
   output logic [RW-1:0] round_o,
   output logic          key_ready_o,
   output logic          busy_o
);

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_EXPAND = 2'(EXPAND);
   localparam logic [1:0] ST_READY  = 2'(READY);
   localparam logic [1:0] ST_REWIND = 2'(REWIND);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   aes_key_t      rk_r;
   aes_key_t      rk_nxt_s;
   logic [RW-1:0] round_r;
   logic [RW-1:0] round_nxt_s;
   logic          key_ready_r;
   logic          busy_r;

   aes_word_t w0_s, w1_s, w2_s, w3_s;
   aes_word_t sub_sel_s, sub_in_s, sub_out_s, rcon_word_s;
   aes_word_t t_s, f0_s, f1_s, f2_s, f3_s, r0_s, r1_s, r2_s, r3_s;
   logic      rev_sel_s;
   logic [3:0] rcon_idx_s;
   aes_key_t  fwd_key_s;
   aes_key_t  rev_key_s;

   assign w0_s = rk_r[127:96];
   assign w1_s = rk_r[95:64];
   assign w2_s = rk_r[63:32];
   assign w3_s = rk_r[31:0];

   // Reverse steps only happen while serving keys; every other step is forward.
   assign rev_sel_s = (state_r == ST_READY);

   // Shared SubWord input and round constant selection.
   always_comb begin
      sub_sel_s  = 32'h0;
      rcon_idx_s = 4'd0;
      if (rev_sel_s) begin
         sub_sel_s  = w2_s ^ w3_s;
         rcon_idx_s = 4'(round_r);
      end else begin
         sub_sel_s  = w3_s;
         rcon_idx_s = 4'(round_r + RW'(1));
      end
   end

   assign sub_in_s    = aes_rot_word(sub_sel_s);
   assign rcon_word_s = {aes_rcon(rcon_idx_s), 24'h000000};

   aes_subword u_subword (
      .word_in  (sub_in_s),
      .word_out (sub_out_s)
   );

   // Forward (r -> r+1) and reverse (r -> r-1) step results.
   always_comb begin
      t_s  = sub_out_s ^ rcon_word_s;
      f0_s = w0_s ^ t_s;
      f1_s = w1_s ^ f0_s;
      f2_s = w2_s ^ f1_s;
      f3_s = w3_s ^ f2_s;
      r3_s = w3_s ^ w2_s;
      r2_s = w2_s ^ w1_s;
      r1_s = w1_s ^ w0_s;
      r0_s = w0_s ^ sub_out_s ^ rcon_word_s;
      fwd_key_s = {f0_s, f1_s, f2_s, f3_s};
      rev_key_s = {r0_s, r1_s, r2_s, r3_s};
   end

`ifdef AES_KS_REWIND_EN
   aes_key_t rk10_r;

   // Snapshot the round-10 key as expansion completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk10_r <= 128'h0;
      end else if (!key_load_i && (state_r == ST_EXPAND) && (round_r == RW'(NR - 1))) begin
         rk10_r <= fwd_key_s;
      end else begin
         rk10_r <= rk10_r;
      end
   end
`endif

   // Next-state logic; load outranks rewind, rewind outranks next.
   always_comb begin
      state_nxt_s = state_r;
      rk_nxt_s    = rk_r;
      round_nxt_s = round_r;
      if (key_load_i) begin
         rk_nxt_s    = key_i;
         round_nxt_s = RW'(0);
         state_nxt_s = ST_EXPAND;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s = ST_IDLE;
            end
            ST_EXPAND, ST_REWIND: begin
               rk_nxt_s    = fwd_key_s;
               round_nxt_s = round_r + RW'(1);
               if (round_r == RW'(NR - 1)) state_nxt_s = ST_READY;
               else                        state_nxt_s = state_r;
            end
            ST_READY: begin
               if (rk_rewind_i) begin
`ifdef AES_KS_REWIND_EN
                  rk_nxt_s    = rk10_r;
                  round_nxt_s = RW'(NR);
                  state_nxt_s = ST_READY;
`else
                  // Already at round 10: nothing to redo.
                  if (round_r == RW'(NR)) state_nxt_s = ST_READY;
                  else                    state_nxt_s = ST_REWIND;
`endif
               end else if (rk_next_i) begin
                  if (round_r != RW'(0)) begin
                     rk_nxt_s    = rev_key_s;
                     round_nxt_s = round_r - RW'(1);
                  end else begin
                     rk_nxt_s    = rk_r;
                     round_nxt_s = round_r;
                  end
               end else begin
                  state_nxt_s = ST_READY;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               rk_nxt_s    = 128'h0;
               round_nxt_s = RW'(0);
            end
         endcase
      end
   end

   // State, key and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         rk_r        <= 128'h0;
         round_r     <= RW'(0);
         key_ready_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         rk_r        <= rk_nxt_s;
         round_r     <= round_nxt_s;
         key_ready_r <= (state_nxt_s == ST_READY);
         busy_r      <= (state_nxt_s == ST_EXPAND) || (state_nxt_s == ST_REWIND);
      end
   end

   assign rk_o        = rk_r;
   assign round_o     = round_r;
   assign key_ready_o = key_ready_r;
   assign busy_o      = busy_r;

endmodule

// File: tb/tb_aes_key_sched_rev.sv
// Self-checking bench for aes_key_sched_rev: FIPS-197 vectors plus random keys
// compared against a key expansion model built from first principles.
module tb_aes_key_sched_rev;

   logic         clk;
   logic         rst_n;
   logic [127:0] key_i;
   logic         key_load_i;
   logic         rk_next_i;
   logic         rk_rewind_i;
   logic [127:0] rk_o;
   logic [3:0]   round_o;
   logic         key_ready_o;
   logic         busy_o;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [7:0]   sbox_m [0:255];
   logic [7:0]   rcon_m [0:10];
   logic [127:0] exp_rk [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes_key_sched_rev dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_i       (key_i),
      .key_load_i  (key_load_i),
      .rk_next_i   (rk_next_i),
      .rk_rewind_i (rk_rewind_i),
      .rk_o        (rk_o),
      .round_o     (round_o),
      .key_ready_o (key_ready_o),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] l, r;
      l = b << n;
      r = b >> (8 - n);
      return l | r;
   endfunction

   task automatic build_tables();
      logic [7:0] p, q, x;
      int rc;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ ((p & 8'h80) != 8'h00 ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if ((q & 8'h80) != 8'h00) q = q ^ 8'h09;
         x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
         sbox_m[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_m[0] = 8'h63;
      rc = 1;
      rcon_m[0] = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         rcon_m[i] = rc[7:0];
         rc = rc * 2;
         if (rc > 255) rc = rc ^ 32'h11b;
      end
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t = t ^ {rcon_m[i/4], 24'h000000};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] key);
      key_i      = key;
      key_load_i = 1'b1;
      tick();
      key_load_i = 1'b0;
   endtask

   task automatic pulse_next();
      rk_next_i = 1'b1;
      tick();
      rk_next_i = 1'b0;
   endtask

   task automatic load_and_wait(input logic [127:0] key);
      int n;
      load_key(key);
      n = 0;
      while (key_ready_o !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (n != 10) $display("FAIL load_latency: got %0d cycles want 10", n);
      else pass_cnt++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; key_i = 128'h0; key_load_i = 1'b0; rk_next_i = 1'b0; rk_rewind_i = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk_cnt++;
      if ({rk_o, round_o, key_ready_o, busy_o} !== 134'h0)
         $display("FAIL reset_state: got rk=%h rnd=%0d rdy=%b busy=%b want all zero", rk_o, round_o, key_ready_o, busy_o);
      else pass_cnt++;
   endtask

   task automatic test_fips_load();
      load_key(FIPS_KEY);
      chk_cnt++;
      if (rk_o !== FIPS_KEY || round_o !== 4'd0 || busy_o !== 1'b1 || key_ready_o !== 1'b0)
         $display("FAIL load_edge0: got rk=%h rnd=%0d busy=%b want %h 0 1", rk_o, round_o, busy_o, FIPS_KEY);
      else pass_cnt++;
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk_cnt++;
         if (key_ready_o !== (c == 10) || round_o !== 4'(c))
            $display("FAIL expand_cycle%0d: got rdy=%b rnd=%0d want rdy=%b rnd=%0d", c, key_ready_o, round_o, (c == 10), c);
         else pass_cnt++;
      end
      chk_cnt++;
      if (rk_o !== FIPS_R10 || busy_o !== 1'b0)
         $display("FAIL fips_r10: got %h busy=%b want %h busy=0", rk_o, busy_o, FIPS_R10);
      else pass_cnt++;
   endtask

   task automatic test_reverse_walk();
      pulse_next();
      chk_cnt++;
      if (rk_o !== FIPS_R9 || round_o !== 4'd9)
         $display("FAIL walk_r9: got %h rnd=%0d want %h rnd=9", rk_o, round_o, FIPS_R9);
      else pass_cnt++;
      repeat (8) pulse_next();
      chk_cnt++;
      if (rk_o !== FIPS_R1 || round_o !== 4'd1)
         $display("FAIL walk_r1: got %h rnd=%0d want %h rnd=1", rk_o, round_o, FIPS_R1);
      else pass_cnt++;
      pulse_next();
      chk_cnt++;
      if (rk_o !== FIPS_KEY || round_o !== 4'd0 || key_ready_o !== 1'b1)
         $display("FAIL walk_r0: got %h rnd=%0d rdy=%b want %h rnd=0 rdy=1", rk_o, round_o, key_ready_o, FIPS_KEY);
      else pass_cnt++;
      pulse_next();
      chk_cnt++;
      if (rk_o !== FIPS_KEY || round_o !== 4'd0 || key_ready_o !== 1'b1 || busy_o !== 1'b0)
         $display("FAIL walk_below0: got %h rnd=%0d want %h rnd=0 held", rk_o, round_o, FIPS_KEY);
      else pass_cnt++;
   endtask

   task automatic test_rewind();
      int bcnt;
      load_and_wait(FIPS_KEY);
      repeat (7) pulse_next();
      chk_cnt++;
      if (round_o !== 4'd3) $display("FAIL rewind_setup: got rnd=%0d want 3", round_o);
      else pass_cnt++;
      rk_rewind_i = 1'b1;
      tick();
      rk_rewind_i = 1'b0;
`ifdef AES_KS_REWIND_EN
      bcnt = 0;
`else
      chk_cnt++;
      if (key_ready_o !== 1'b0) $display("FAIL rewind_notready: got rdy=%b want 0", key_ready_o);
      else pass_cnt++;
      bcnt = 0;
      while (busy_o === 1'b1 && bcnt < 40) begin
         bcnt++;
         tick();
      end
`endif
      chk_cnt++;
`ifdef AES_KS_REWIND_EN
      if (bcnt != 0 || busy_o !== 1'b0)
`else
      if (bcnt != 7)
`endif
         $display("FAIL rewind_busy_cycles: got %0d busy=%b", bcnt, busy_o);
      else pass_cnt++;
      chk_cnt++;
      if (rk_o !== FIPS_R10 || round_o !== 4'd10 || key_ready_o !== 1'b1)
         $display("FAIL rewind_result: got %h rnd=%0d rdy=%b want %h rnd=10", rk_o, round_o, key_ready_o, FIPS_R10);
      else pass_cnt++;
      // Rewind at round 10 completes at once.
      rk_rewind_i = 1'b1;
      tick();
      rk_rewind_i = 1'b0;
      chk_cnt++;
      if (rk_o !== FIPS_R10 || round_o !== 4'd10 || busy_o !== 1'b0 || key_ready_o !== 1'b1)
         $display("FAIL rewind_at10: got %h rnd=%0d busy=%b want %h rnd=10 busy=0", rk_o, round_o, busy_o, FIPS_R10);
      else pass_cnt++;
   endtask

   task automatic test_load_mid_expand();
      load_key(FIPS_KEY);
      repeat (4) tick();
      load_key(SEQ_KEY);
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk_cnt++;
         if (key_ready_o !== (c == 10))
            $display("FAIL reload_cycle%0d: got rdy=%b want %b", c, key_ready_o, (c == 10));
         else pass_cnt++;
      end
      chk_cnt++;
      if (rk_o !== SEQ_R10 || round_o !== 4'd10)
         $display("FAIL reload_r10: got %h rnd=%0d want %h rnd=10", rk_o, round_o, SEQ_R10);
      else pass_cnt++;
   endtask

   task automatic test_random_walk();
      logic [127:0] key;
      int r;
      for (int n = 0; n < 6; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         model_expand(key);
         load_key(key);
         // Next requests during expansion must be ignored.
         for (int c = 1; c <= 10; c++) begin
            rk_next_i = 1'($urandom_range(0, 1));
            tick();
         end
         rk_next_i = 1'b0;
         chk_cnt++;
         if (rk_o !== exp_rk[10] || round_o !== 4'd10 || key_ready_o !== 1'b1)
            $display("FAIL rand_r10[%0d]: got %h rnd=%0d want %h", n, rk_o, round_o, exp_rk[10]);
         else pass_cnt++;
         r = 10;
         for (int s = 0; s < 12; s++) begin
            if ($urandom_range(0, 3) == 0) tick();
            pulse_next();
            if (r > 0) r--;
            chk_cnt++;
            if (rk_o !== exp_rk[r] || round_o !== 4'(r))
               $display("FAIL rand_walk[%0d.%0d]: got %h rnd=%0d want %h rnd=%0d", n, s, rk_o, round_o, exp_rk[r], r);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid_walk();
      load_and_wait(FIPS_KEY);
      repeat (6) pulse_next();
      #2;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({rk_o, round_o, key_ready_o, busy_o} !== 134'h0)
         $display("FAIL async_reset: got rk=%h rnd=%0d rdy=%b busy=%b want zero", rk_o, round_o, key_ready_o, busy_o);
      else pass_cnt++;
      tick();
      rst_n = 1'b1;
      pulse_next();
      chk_cnt++;
      if ({rk_o, round_o, key_ready_o, busy_o} !== 134'h0)
         $display("FAIL idle_next_ignored: got rk=%h rnd=%0d rdy=%b want zero", rk_o, round_o, key_ready_o);
      else pass_cnt++;
   endtask

   task automatic test_next_and_rewind();
      int n;
      logic saw4;
      load_and_wait(FIPS_KEY);
      repeat (5) pulse_next();
      rk_next_i   = 1'b1;
      rk_rewind_i = 1'b1;
      tick();
      rk_next_i   = 1'b0;
      rk_rewind_i = 1'b0;
      saw4 = (round_o < 4'd5);
      n = 0;
      while (key_ready_o !== 1'b1 && n < 40) begin
         tick();
         if (round_o < 4'd5) saw4 = 1'b1;
         n++;
      end
      chk_cnt++;
      if (saw4 || rk_o !== FIPS_R10 || round_o !== 4'd10)
         $display("FAIL next_vs_rewind: got %h rnd=%0d went_down=%b want %h rnd=10", rk_o, round_o, saw4, FIPS_R10);
      else pass_cnt++;
   endtask

   initial begin
      build_tables();
      test_reset();
      test_fips_load();
      test_reverse_walk();
      test_rewind();
      test_load_mid_expand();
      test_random_walk();
      test_next_and_rewind();
      test_reset_mid_walk();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
